// File: rtl/stutter_prog_pkg.sv
// Shared opcode constants and instruction field-layout helpers for the stutter program block.
// An instruction is {op[2:0], dst, src}, where dst and src are RIDX_W bits wide.
package stutter_prog_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDS  = 3'd1;
    localparam logic [2:0] OP_LDP  = 3'd2;
    localparam logic [2:0] OP_OUTS = 3'd3;
    localparam logic [2:0] OP_OUTP = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_BZ   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    function automatic int instrWidth(input int ridxW);
        return 3 + 2 * ridxW;
    endfunction

    // The instruction is zero-extended to 32 bits so one helper serves every register-file size.
    function automatic logic [2:0] instrOp(input logic [31:0] instr, input int ridxW);
        return instr[2 * ridxW +: 3];
    endfunction

    function automatic logic [31:0] instrDst(input logic [31:0] instr, input int ridxW);
        return (instr >> ridxW) & ((32'd1 << ridxW) - 32'd1);
    endfunction

    function automatic logic [31:0] instrSrc(input logic [31:0] instr, input int ridxW);
        return instr & ((32'd1 << ridxW) - 32'd1);
    endfunction

endpackage

// File: rtl/stutter_prog_decode.sv
// Combinational instruction decoder: splits an instruction into its fields and derives
// the one-hot register write enable and the one-hot write-data source select.
module stutter_prog_decode
    import stutter_prog_pkg::*;
#(
    parameter int NUM_REGS = 2
) (
    input  logic [instrWidth($clog2(NUM_REGS))-1:0] i_instr,
    output logic [2:0]                              o_op,
    output logic [$clog2(NUM_REGS)-1:0]             o_dst,
    output logic [$clog2(NUM_REGS)-1:0]             o_src,
    output logic [NUM_REGS-1:0]                     o_wrEn,
    output logic [2:0]                              o_wrSel
);

    localparam int RIDX_W = $clog2(NUM_REGS);

    // o_wrSel: bit 0 = secret input, bit 1 = public input, bit 2 = register source.
    always_comb begin
        o_op    = instrOp(32'(i_instr), RIDX_W);
        o_dst   = RIDX_W'(instrDst(32'(i_instr), RIDX_W));
        o_src   = RIDX_W'(instrSrc(32'(i_instr), RIDX_W));
        o_wrSel = 3'b000;
        o_wrEn  = '0;
        case (o_op)
            OP_LDS:  o_wrSel = 3'b001;
            OP_LDP:  o_wrSel = 3'b010;
            OP_MOV:  o_wrSel = 3'b100;
            default: o_wrSel = 3'b000;
        endcase
        for (int j = 0; j < NUM_REGS; j++) begin
            o_wrEn[j] = (|o_wrSel) && (o_dst == RIDX_W'(j));
        end
    end

endmodule

// File: rtl/stutter_prog_block.sv
// Executes a parameterised straight-line/skip program over a small register file, one step
// per non-stuttered cycle. Optional macro STUTTER_FAIR_EN forces a step after MAX_STUTTER stalls.
module stutter_prog_block
    import stutter_prog_pkg::*;
#(
    parameter int W           = 1,
    parameter int NUM_REGS    = 2,
    parameter int PROG_LEN    = 4,
    parameter logic [PROG_LEN*(3+2*$clog2(NUM_REGS))-1:0] PROG = 20'hE3080,
    parameter int MAX_STUTTER = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stutter_in,
    input  logic [W-1:0]                  secret_in,
    input  logic [W-1:0]                  public_in,
    output logic [W-1:0]                  secret_out,
    output logic [W-1:0]                  public_out,
    output logic                          stutter,
    output logic [$clog2(PROG_LEN+1)-1:0] pc,
    output logic                          done
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam int IW     = instrWidth(RIDX_W);
    localparam int PC_W   = $clog2(PROG_LEN + 1);

    logic [W-1:0]        r_regs [NUM_REGS];
    logic [IW-1:0]       w_instr;
    logic [2:0]          w_op;
    logic [RIDX_W-1:0]   w_dst;
    logic [RIDX_W-1:0]   w_src;
    logic [NUM_REGS-1:0] w_wrEn;
    logic [2:0]          w_wrSel;
    logic [W-1:0]        w_srcVal;
    logic [W-1:0]        w_wrData;
    logic [PC_W:0]       w_pcSum;
    logic [PC_W-1:0]     w_pcNext;
    logic                w_doneNext;
    logic                w_effStutter;
    logic                w_step;

    // Fetch by comparison so a saturated pc (== PROG_LEN) never indexes past the program.
    always_comb begin
        w_instr = '0;
        for (int i = 0; i < PROG_LEN; i++) begin
            if (pc == PC_W'(i)) w_instr = PROG[i*IW +: IW];
        end
    end

    stutter_prog_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .i_instr (w_instr),
        .o_op    (w_op),
        .o_dst   (w_dst),
        .o_src   (w_src),
        .o_wrEn  (w_wrEn),
        .o_wrSel (w_wrSel)
    );

`ifdef STUTTER_FAIR_EN
    localparam int CNT_W = $clog2(MAX_STUTTER + 1);

    logic [CNT_W-1:0] r_stallCnt;
    logic             w_force;

    assign w_force      = !done && (r_stallCnt == CNT_W'(MAX_STUTTER));
    assign w_effStutter = stutter_in && !w_force;

    // Counts consecutive stalls of a running program; any step, or finishing, clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_step || done) begin
            r_stallCnt <= '0;
        end else if (stutter_in) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end
`else
    logic w_unusedMaxStutter;

    assign w_unusedMaxStutter = (MAX_STUTTER > 0);
    assign w_effStutter       = stutter_in;
`endif

    assign w_step   = !w_effStutter && !done;
    assign w_srcVal = r_regs[w_src];

    always_comb begin
        w_wrData = w_srcVal;
        if (w_wrSel[0]) w_wrData = secret_in;
        else if (w_wrSel[1]) w_wrData = public_in;
    end

    // BZ may skip past the end; pc saturates at PROG_LEN, which also finishes the program.
    always_comb begin
        w_pcSum = {1'b0, pc} + ((w_op == OP_BZ && w_srcVal == '0) ? (PC_W+1)'(2) : (PC_W+1)'(1));
        if (w_op == OP_HALT) w_pcNext = pc;
        else if (w_pcSum >= (PC_W+1)'(PROG_LEN)) w_pcNext = PC_W'(PROG_LEN);
        else w_pcNext = w_pcSum[PC_W-1:0];
        w_doneNext = (w_op == OP_HALT) || (w_pcNext == PC_W'(PROG_LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            done       <= 1'b0;
            secret_out <= '0;
            public_out <= '0;
            stutter    <= 1'b0;
            for (int j = 0; j < NUM_REGS; j++) r_regs[j] <= '0;
        end else begin
            stutter <= w_effStutter;
            if (w_step) begin
                pc   <= w_pcNext;
                done <= w_doneNext;
                if (w_wrEn[w_dst]) r_regs[w_dst] <= w_wrData;
                if (w_op == OP_OUTS) secret_out <= w_srcVal;
                if (w_op == OP_OUTP) public_out <= w_srcVal;
            end
        end
    end

endmodule

// File: tb/tb_stutter_prog_block.sv
// Self-checking bench for stutter_prog_block: three program variants driven together and
// compared against an instruction-level interpreter; honours STUTTER_FAIR_EN when defined.
module tb_stutter_prog_block;

    logic       clk = 1'b0;
    logic       rst;
    logic       stutterIn;
    logic [3:0] secretIn;
    logic [3:0] publicIn;

    logic       aSec, aPub, aStut, aDone;
    logic [2:0] aPc;
    logic [3:0] bSec, bPub;
    logic       bStut, bDone;
    logic [2:0] bPc;
    logic [3:0] cSec, cPub;
    logic       cStut, cDone;
    logic [1:0] cPc;

    int passCount  = 0;
    int checkCount = 0;

    localparam int MAX_STALL = 3;

    // Reference interpreter state, one slot per DUT variant.
    int progLen [3];
    int progOp  [3][4];
    int progDst [3][4];
    int progSrc [3][4];
    int wMask   [3];
    int mPc [3], mDone [3], mSo [3], mPo [3], mStut [3], mCnt [3];
    int mReg [3][2];

    logic [17:0] obs [3];

    always #5 clk = ~clk;

    stutter_prog_block dutA (
        .clk(clk), .rst(rst), .stutter_in(stutterIn),
        .secret_in(secretIn[0]), .public_in(publicIn[0]),
        .secret_out(aSec), .public_out(aPub), .stutter(aStut), .pc(aPc), .done(aDone)
    );

    stutter_prog_block #(
        .W(4), .NUM_REGS(2), .PROG_LEN(4),
        .PROG({5'b11100, 5'b10000, 5'b11000, 5'b01000})
    ) dutB (
        .clk(clk), .rst(rst), .stutter_in(stutterIn),
        .secret_in(secretIn), .public_in(publicIn),
        .secret_out(bSec), .public_out(bPub), .stutter(bStut), .pc(bPc), .done(bDone)
    );

    stutter_prog_block #(
        .W(4), .NUM_REGS(2), .PROG_LEN(2),
        .PROG({5'b11000, 5'b01000})
    ) dutC (
        .clk(clk), .rst(rst), .stutter_in(stutterIn),
        .secret_in(secretIn), .public_in(publicIn),
        .secret_out(cSec), .public_out(cPub), .stutter(cStut), .pc(cPc), .done(cDone)
    );

    function automatic logic [17:0] packState(input int pcV, input int doneV, input int so,
                                              input int po, input int st);
        return {8'(pcV), 1'(doneV), 4'(so), 4'(po), 1'(st)};
    endfunction

    always_comb begin
        obs[0] = packState(int'(aPc), int'(aDone), int'(aSec), int'(aPub), int'(aStut));
        obs[1] = packState(int'(bPc), int'(bDone), int'(bSec), int'(bPub), int'(bStut));
        obs[2] = packState(int'(cPc), int'(cDone), int'(cSec), int'(cPub), int'(cStut));
    end

    // Executes one program step per non-held cycle, straight from the opcode meanings.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mPc[d] = 0; mDone[d] = 0; mSo[d] = 0; mPo[d] = 0; mStut[d] = 0; mCnt[d] = 0;
                mReg[d][0] = 0; mReg[d][1] = 0;
            end else begin
                bit hold;
                int op, dst, src, srcVal, nextPc;
                hold = stutterIn;
`ifdef STUTTER_FAIR_EN
                if (mDone[d] == 0 && mCnt[d] >= MAX_STALL) hold = 1'b0;
`endif
                mStut[d] = int'(hold);
                if (!hold && mDone[d] == 0) begin
                    op     = progOp[d][mPc[d]];
                    dst    = progDst[d][mPc[d]];
                    src    = progSrc[d][mPc[d]];
                    srcVal = mReg[d][src];
                    nextPc = mPc[d] + 1;
                    case (op)
                        1: mReg[d][dst] = int'(secretIn) & wMask[d];
                        2: mReg[d][dst] = int'(publicIn) & wMask[d];
                        3: mSo[d] = srcVal;
                        4: mPo[d] = srcVal;
                        5: mReg[d][dst] = srcVal;
                        6: if (srcVal == 0) nextPc = mPc[d] + 2;
                        7: begin nextPc = mPc[d]; mDone[d] = 1; end
                        default: ;
                    endcase
                    if (nextPc >= progLen[d]) begin
                        nextPc   = progLen[d];
                        mDone[d] = 1;
                    end
                    mPc[d]  = nextPc;
                    mCnt[d] = 0;
                end else if (stutterIn && mDone[d] == 0) begin
                    mCnt[d] = mCnt[d] + 1;
                end else begin
                    mCnt[d] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        stutterIn = 1'b0;
        secretIn  = 4'h0;
        publicIn  = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        for (int d = 0; d < 3; d++) begin
            checkCount++;
            if (obs[d] !== packState(0, 0, 0, 0, 0))
                $display("[TB] FAIL reset_state dut%0d: got %h expected %h", d, obs[d], packState(0, 0, 0, 0, 0));
            else passCount++;
        end
    endtask

    task automatic test_straight_line();
        applyReset();
        stutterIn = 1'b0;
        secretIn  = 4'hF;
        for (int e = 1; e <= 4; e++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checkCount++;
                if (obs[d] !== packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]))
                    $display("[TB] FAIL straight_model dut%0d edge%0d: got %h expected %h", d, e, obs[d],
                             packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]));
                else passCount++;
            end
            if (e == 3) begin
                checkCount++;
                if (aSec !== 1'b1) $display("[TB] FAIL straight_secret_out: got %b expected 1", aSec);
                else passCount++;
            end
            if (e == 4) begin
                checkCount++;
                if (aDone !== 1'b1 || aPc !== 3'd3 || aPub !== 1'b0)
                    $display("[TB] FAIL straight_halt: got done=%b pc=%0d pub=%b expected done=1 pc=3 pub=0",
                             aDone, aPc, aPub);
                else passCount++;
            end
        end
    endtask

    task automatic test_stall();
        int expPc, expSt;
        applyReset();
        secretIn  = 4'h1;
        stutterIn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
`ifdef STUTTER_FAIR_EN
            expPc = (c >= 4) ? 1 : 0;
            expSt = (c == 4) ? 0 : 1;
`else
            expPc = 0;
            expSt = 1;
`endif
            checkCount++;
            if (int'(aPc) !== expPc || int'(aStut) !== expSt)
                $display("[TB] FAIL stall_cycle%0d: got pc=%0d stutter=%b expected pc=%0d stutter=%0d",
                         c, aPc, aStut, expPc, expSt);
            else passCount++;
        end
        stutterIn = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            tick();
            checkCount++;
            if (obs[0] !== packState(mPc[0], mDone[0], mSo[0], mPo[0], mStut[0]))
                $display("[TB] FAIL stall_release_model edge%0d: got %h expected %h", r, obs[0],
                         packState(mPc[0], mDone[0], mSo[0], mPo[0], mStut[0]));
            else passCount++;
        end
        checkCount++;
        if (aSec !== 1'b1) $display("[TB] FAIL stall_secret_out: got %b expected 1", aSec);
        else passCount++;
    endtask

    task automatic test_branch();
        logic [3:0] pub;
        int stepsToDone;
        for (int k = 0; k < 2; k++) begin
            pub = (k == 1) ? 4'hA : 4'h0;
            applyReset();
            publicIn    = pub;
            stutterIn   = 1'b0;
            stepsToDone = 0;
            for (int e = 1; e <= 6; e++) begin
                tick();
                if (bDone === 1'b1 && stepsToDone == 0) stepsToDone = e;
                for (int d = 1; d < 3; d++) begin
                    checkCount++;
                    if (obs[d] !== packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]))
                        $display("[TB] FAIL branch_model dut%0d pub=%h edge%0d: got %h expected %h", d, pub, e,
                                 obs[d], packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]));
                    else passCount++;
                end
                if (e == 2) begin
                    checkCount++;
                    if (cDone !== 1'b1 || cPc !== 2'd2)
                        $display("[TB] FAIL branch_end_saturate pub=%h: got pc=%0d done=%b expected pc=2 done=1",
                                 pub, cPc, cDone);
                    else passCount++;
                end
            end
            checkCount++;
            if (bPub !== pub) $display("[TB] FAIL branch_public_out: got %h expected %h", bPub, pub);
            else passCount++;
            checkCount++;
            if (stepsToDone != ((k == 1) ? 4 : 3))
                $display("[TB] FAIL branch_steps pub=%h: got %0d expected %0d", pub, stepsToDone, (k == 1) ? 4 : 3);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        stutterIn = 1'b0;
        secretIn  = 4'h1;
        tick();
        tick();
        tick();
        checkCount++;
        if (aSec !== 1'b1) $display("[TB] FAIL midreset_pre_secret: got %b expected 1", aSec);
        else passCount++;
        rst       = 1'b1;
        stutterIn = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            checkCount++;
            if (obs[d] !== packState(0, 0, 0, 0, 0))
                $display("[TB] FAIL midreset_clear dut%0d: got %h expected %h", d, obs[d], packState(0, 0, 0, 0, 0));
            else passCount++;
        end
        rst       = 1'b0;
        stutterIn = 1'b0;
        tick();
        checkCount++;
        if (aPc !== 3'd1 || aSec !== 1'b0 || aDone !== 1'b0)
            $display("[TB] FAIL midreset_restart: got pc=%0d sec=%b done=%b expected pc=1 sec=0 done=0",
                     aPc, aSec, aDone);
        else passCount++;
    endtask

    task automatic test_random_and_frozen();
        logic [16:0] frozen [3];
        int waited;
        applyReset();
        for (int c = 0; c < 30; c++) begin
            stutterIn = ($urandom_range(0, 2) == 0);
            secretIn  = 4'($urandom);
            publicIn  = 4'($urandom);
            tick();
            for (int d = 0; d < 3; d++) begin
                checkCount++;
                if (obs[d] !== packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]))
                    $display("[TB] FAIL random_model dut%0d cycle%0d: got %h expected %h", d, c, obs[d],
                             packState(mPc[d], mDone[d], mSo[d], mPo[d], mStut[d]));
                else passCount++;
            end
        end
        stutterIn = 1'b0;
        waited    = 0;
        while (!(aDone === 1'b1 && bDone === 1'b1 && cDone === 1'b1) && waited < 10) begin
            tick();
            waited++;
        end
        checkCount++;
        if (!(aDone === 1'b1 && bDone === 1'b1 && cDone === 1'b1))
            $display("[TB] FAIL frozen_reach_done: got done=%b%b%b expected 111", aDone, bDone, cDone);
        else passCount++;
        for (int d = 0; d < 3; d++) frozen[d] = obs[d][17:1];
        for (int c = 0; c < 10; c++) begin
            stutterIn = 1'($urandom);
            secretIn  = 4'($urandom);
            publicIn  = 4'($urandom);
            tick();
            for (int d = 0; d < 3; d++) begin
                checkCount++;
                if (obs[d][17:1] !== frozen[d] || obs[d][0] !== stutterIn)
                    $display("[TB] FAIL frozen_dut%0d cycle%0d: got %h expected %h", d, c, obs[d],
                             {frozen[d], stutterIn});
                else passCount++;
            end
        end
    endtask

    initial begin
        progLen = '{4, 4, 2};
        wMask   = '{1, 15, 15};
        progOp  = '{'{0, 1, 3, 7}, '{2, 6, 4, 7}, '{2, 6, 0, 0}};
        progDst = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        progSrc = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        rst       = 1'b1;
        stutterIn = 1'b0;
        secretIn  = 4'h0;
        publicIn  = 4'h0;

        test_reset();
        test_straight_line();
        test_stall();
        test_branch();
        test_reset_mid();
        test_random_and_frozen();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/stutter_prog_block.md
Name: stutter_prog_block

Overview:
Parametrised successor to the fixed per-step codeblock models used in the asynchronous-HyperLTL compiler-optimisation case studies. It executes a small straight-line/skip program held in a parameter over a W-bit register file. Each program step is gated by a stutter input. Source and target variants of an optimisation (e.g. dead-branch elimination) are built from one module by changing PROG, instead of hand-writing a case statement per variant.

Parameters:
W, 1, data width of secret/public inputs, outputs and registers
NUM_REGS, 2, register-file entries (power of two, >=2); RIDX_W = clog2(NUM_REGS)
PROG_LEN, 4, number of instructions; PC_W = clog2(PROG_LEN+1)
PROG, 20'hE3080, packed program; instr i = PROG[i*IW +: IW], IW = 3+2*RIDX_W, fields {op[2:0], dst, src}; default = NOP; LDS r0; OUTS r0; HALT
MAX_STUTTER, 3, consecutive-stutter bound (used only with the optional feature)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
stutter_in  in  1  1 = hold this cycle, no step executed
secret_in  in  W  secret input value
public_in  in  W  public input value
secret_out  out  W  registered secret output
public_out  out  W  registered public output
stutter  out  1  registered copy of stutter_in
pc  out  PC_W  index of next instruction
done  out  1  program finished (HALT executed or pc == PROG_LEN)

Behaviour:
- Reset (rst=1 at posedge): pc, done, secret_out, public_out, stutter, all regs <= 0. Reset wins over stutter and over any instruction.
- stutter <= stutter_in every non-reset cycle, including after done.
- Step condition: !rst && !stutter_in && !done. When no step: pc, regs and outputs hold.
- A step executes PROG[pc] and updates state at the same edge (latency 1 cycle per step).
- Opcodes:
  - 0 NOP: no data change.
  - 1 LDS: r[dst] <= secret_in.
  - 2 LDP: r[dst] <= public_in.
  - 3 OUTS: secret_out <= r[src].
  - 4 OUTP: public_out <= r[src].
  - 5 MOV: r[dst] <= r[src].
  - 6 BZ: if r[src]==0, pc += 2; otherwise pc += 1.
  - 7 HALT: done <= 1, pc unchanged.
- All opcodes except BZ and HALT: pc += 1.
- Register reads use the pre-edge value (MOV r0,r0 is a no-op).
- pc saturates at PROG_LEN. A BZ skip past the end gives pc = PROG_LEN. On reaching PROG_LEN, done <= 1 at the same edge.
- done is sticky until reset. After done, stutter_in has no effect except on the stutter output.
- Outputs change only via OUTS/OUTP or reset. There are no combinational paths from inputs to outputs.
- Out-of-range dst/src cannot occur (power-of-two register file). Unused instruction fields are ignored.

Optional Feature:
STUTTER_FAIR_EN.
- Defined: a counter tracks consecutive cycles with stutter_in=1 while !done. Once it reaches MAX_STUTTER, the next cycle steps regardless of stutter_in. The counter clears on any step or on reset. The stutter output then reports the effective stutter (0 on a forced step). This models fair scheduling.
- Undefined: no counter; stutter_in may hold indefinitely; stutter = registered stutter_in.

Decomposition:
- Package stutter_prog_pkg holds:
  - opcode constants OP_NOP..OP_HALT (3-bit);
  - the field-layout functions: instr width and op/dst/src extraction for given RIDX_W.
- Sub-module stutter_prog_decode (combinational) takes instr and emits op, dst, src, and one-hot write-enable/select signals. The top keeps pc, the register file, the outputs and the fairness counter.

Test Plan:
1. Default params, rst for 2 cycles, then stutter_in=0, secret_in=1 held.
   - After edge 2 (LDS): r0=1. After edge 3: secret_out=1.
   - After edge 4: done=1, pc=3. public_out stays 0.
2. Default params, stutter_in=1 for 5 cycles after reset, then 0.
   - pc stays 0 and stutter=1 during the stall; secret_out=1 three steps after release.
   - With STUTTER_FAIR_EN and MAX_STUTTER=3: pc=1 after the 4th cycle despite stutter_in=1, and stutter=0 that cycle.
3. Program "LDP r0; BZ r0; OUTP r0; HALT" (W=4):
   - public_in=0 → skip → public_out stays 0, done after 3 steps.
   - public_in=4'hA → public_out=4'hA, done after 4 steps.
4. Program ending in BZ at index PROG_LEN-1 with r=0 → pc=PROG_LEN (saturated) and done=1 on that edge; no wrap to 0.
5. Assert rst mid-program (after OUTS, secret_out=1) with stutter_in=1 simultaneously → next cycle all outputs, pc and done are 0; execution restarts from pc 0.
6. After done, toggle stutter_in and secret_in randomly for 10 cycles → pc, done and outputs frozen; stutter tracks stutter_in with 1-cycle delay.
